tile_buffer_reader: RTL and testbench
=====================================

// Module: tile_buffer_reader
// PURPOSE
//  Read side of the tile buffer SRAM: fetches packed 9-pixel tile rows written by the tile gatherer.
//  Unpacks each 64-bit word into nine 4-bit pixels and presents them to the PE array with valid/ready.
//  Operates as a circular-buffer consumer; it never reads past the writer's pointer.
// PARAMETERS
//  TILE_SIZE    9    pixels per row word / PE array rows fed per beat
//  PIX_W        4    bits per pixel
//  DATA_WIDTH   64   SRAM word width; pixels occupy bits [TILE_SIZE*PIX_W-1:0]
//  ADDR_WIDTH   10   SRAM address width
//  SRAM_DEPTH   1024 words in buffer; pointer wrap point
//  READ_LAT     2    cycles from csb-low request edge to valid sram_dout
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  start      in   1            1-cycle pulse: begin a job (ignored while busy)
//  num_rows   in   16           rows to deliver for this job, sampled at start
//  wr_ptr     in   ADDR_WIDTH   writer's next-write address (rows < wr_ptr are valid)
//  csb        out  1            SRAM chip select, active-low
//  we         out  1            SRAM write enable, active-low; tied high (read only)
//  wmask      out  8            SRAM write mask; driven all-zero
//  addr       out  ADDR_WIDTH   SRAM read address
//  sram_dout  in   DATA_WIDTH   SRAM read data
//  pe_data    out  PIX_W x TILE_SIZE  unpacked pixel array [0:TILE_SIZE-1] to PE array
//  pe_valid   out  1            pe_data holds an unconsumed row
//  pe_ready   in   1            PE array accepts row when pe_valid&&pe_ready at clk edge
//  busy       out  1            job in progress
//  done       out  1            1-cycle pulse after last row accepted
// BEHAVIOUR
//  Reset: csb=1, we=1, wmask=0, addr=0, pe_data all 0, pe_valid=0, busy=0, done=0, rd_ptr=0, state=IDLE.
//  rd_ptr persists across jobs (not cleared by start); only rst clears it.
//  FSM: IDLE -> REQ -> WAIT -> HOLD -> (REQ | IDLE).
//   IDLE: on start && num_rows!=0: latch rows_left=num_rows, busy=1, go REQ.
//         start && num_rows==0: done=1 next cycle, busy stays 0, remain IDLE.
//   REQ : if rd_ptr==wr_ptr (empty): csb=1, stall in REQ. Else csb=0, addr=rd_ptr for exactly
//         one cycle, rd_ptr<=(rd_ptr==SRAM_DEPTH-1)?0:rd_ptr+1, lat_cnt=0, go WAIT.
//   WAIT: csb=1; count READ_LAT cycles; on final count capture pe_data[i]=sram_dout[PIX_W*i+:PIX_W]
//         for i=0..TILE_SIZE-1, set pe_valid=1, go HOLD. Bits above TILE_SIZE*PIX_W ignored.
//   HOLD: pe_data/pe_valid stable until pe_valid&&pe_ready. On handshake: pe_valid=0, rows_left-=1;
//         if rows_left was 1: done=1 (one cycle), busy=0, go IDLE; else go REQ.
//  Latency: first pe_valid no earlier than READ_LAT+2 cycles after start (non-empty buffer).
//  Throughput: at most one row per READ_LAT+2 cycles; no read issued while a row is held.
//  Empty check uses wr_ptr sampled in REQ; full/overrun prevention is the writer's duty.
//  pe_ready while pe_valid=0 has no effect. start during busy ignored, not queued.
//  Reset mid-job (any state): immediate return to reset values; in-flight SRAM read discarded.
// STRUCTURE
//  Shared package tile_buf_pkg: TILE_SIZE, PIX_W, DATA_WIDTH, ADDR_WIDTH, SRAM_DEPTH, READ_LAT,
//   rd_state_t enum {RD_IDLE, RD_REQ, RD_WAIT, RD_HOLD}; same package used by the tile gatherer.
//  Sub-module tile_row_unpack (combinational): DATA_WIDTH word -> PIX_W x TILE_SIZE array.
// TESTING
//  1 Reset: assert rst mid-WAIT -> csb=1, we=1, pe_valid=0, busy=0, rd_ptr=0 same cycle.
//  2 Single row: word 0 = 64'h0000_0008_7654_3210, wr_ptr=1, start num_rows=1 -> addr=0,
//    pe_data={0,1,..,8} valid at cycle READ_LAT+2; pe_ready=1 -> done pulse, busy=0.
//  3 Backpressure: num_rows=3, pe_ready=0 for 10 cycles -> pe_data stable, csb stays 1, 1 read only.
//  4 Empty stall: wr_ptr=0, start num_rows=2 -> csb=1 in REQ; raise wr_ptr to 2 -> 2 rows delivered.
//  5 Wrap: rd_ptr=1022, wr_ptr=2, num_rows=4 -> addrs 1022,1023,0,1 in order, done after 4th.
//  6 num_rows=0 -> done pulse next cycle, no csb low; start while busy -> ignored, rows_left unchanged.

Source files
------------

// File: rtl/tile_buf_pkg.sv
// Shared tile buffer constants and read-side state type, common to the gatherer and the reader.
package tile_buf_pkg;
  localparam int TILE_SIZE  = 9;
  localparam int PIX_W      = 4;
  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 10;
  localparam int SRAM_DEPTH = 1024;
  localparam int READ_LAT   = 2;
  localparam int ROW_W      = TILE_SIZE * PIX_W;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    RD_HOLD = 2'd3
  } rd_state_t;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(SRAM_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/tile_row_unpack.sv
// Splits one SRAM word into TILE_SIZE pixels; pixel i sits at bits [PIX_W*i +: PIX_W].
module tile_row_unpack
  import tile_buf_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]            i_word,
  output logic [TILE_SIZE-1:0][PIX_W-1:0]  o_pix
);
  for (genvar i = 0; i < TILE_SIZE; i++) begin : g_pix
    assign o_pix[i] = i_word[PIX_W*i +: PIX_W];
  end

  // Bits above the packed row carry nothing for the PE array.
  logic w_unused_hi;
  assign w_unused_hi = ^i_word[DATA_WIDTH-1:ROW_W];
endmodule

// File: rtl/tile_buffer_reader.sv
// Tile buffer read side: circular consumer that fetches one row word at a time and hands it to the PE array.
module tile_buffer_reader
  import tile_buf_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [15:0]                     i_num_rows,
  input  logic [ADDR_WIDTH-1:0]           i_wr_ptr,
  output logic                            o_csb,
  output logic                            o_we,
  output logic [7:0]                      o_wmask,
  output logic [ADDR_WIDTH-1:0]           o_addr,
  input  logic [DATA_WIDTH-1:0]           i_sram_dout,
  output logic [TILE_SIZE-1:0][PIX_W-1:0] o_pe_data,
  output logic                            o_pe_valid,
  input  logic                            i_pe_ready,
  output logic                            o_busy,
  output logic                            o_done
);
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  rd_state_t                       r_state;
  logic [ADDR_WIDTH-1:0]           r_rd_ptr;
  logic [15:0]                     r_rows_left;
  logic [LAT_W-1:0]                r_lat_cnt;
  logic [TILE_SIZE-1:0][PIX_W-1:0] r_pe_data;
  logic                            r_pe_valid;
  logic                            r_done;

  logic                            w_rd_en;
  logic [TILE_SIZE-1:0][PIX_W-1:0] w_row;

  tile_row_unpack u_unpack (
    .i_word (i_sram_dout),
    .o_pix  (w_row)
  );

  // A read is issued only in REQ and only when the writer is ahead of us.
  assign w_rd_en    = (r_state == RD_REQ) && (r_rd_ptr != i_wr_ptr);
  assign o_csb      = ~w_rd_en;
  assign o_we       = 1'b1;
  assign o_wmask    = '0;
  assign o_addr     = r_rd_ptr;
  assign o_pe_data  = r_pe_data;
  assign o_pe_valid = r_pe_valid;
  assign o_busy     = (r_state != RD_IDLE);
  assign o_done     = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RD_IDLE;
      r_rd_ptr    <= '0;
      r_rows_left <= '0;
      r_lat_cnt   <= '0;
      r_pe_data   <= '0;
      r_pe_valid  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RD_IDLE: begin
          if (i_start) begin
            if (i_num_rows != '0) begin
              r_rows_left <= i_num_rows;
              r_state     <= RD_REQ;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (w_rd_en) begin
            r_rd_ptr  <= ptr_inc(r_rd_ptr);
            r_lat_cnt <= '0;
            r_state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Final count lines up with the SRAM word landing on i_sram_dout.
          if (r_lat_cnt == LAT_W'(READ_LAT - 1)) begin
            r_pe_data  <= w_row;
            r_pe_valid <= 1'b1;
            r_state    <= RD_HOLD;
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end
        RD_HOLD: begin
          if (r_pe_valid && i_pe_ready) begin
            r_pe_valid  <= 1'b0;
            r_rows_left <= r_rows_left - 1'b1;
            if (r_rows_left == 16'd1) begin
              r_done  <= 1'b1;
              r_state <= RD_IDLE;
            end else begin
              r_state <= RD_REQ;
            end
          end
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_buffer_reader.sv
// Randomized bench for tile_buffer_reader: SRAM model, read-order/row-content scoreboard, directed corner jobs.
module tb_tile_buffer_reader;
  import tile_buf_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst = 1'b1;
  logic                            i_start = 1'b0;
  logic [15:0]                     i_num_rows = '0;
  logic [ADDR_WIDTH-1:0]           i_wr_ptr = '0;
  logic                            o_csb, o_we;
  logic [7:0]                      o_wmask;
  logic [ADDR_WIDTH-1:0]           o_addr;
  logic [DATA_WIDTH-1:0]           i_sram_dout = '0;
  logic [TILE_SIZE-1:0][PIX_W-1:0] o_pe_data;
  logic                            o_pe_valid;
  logic                            i_pe_ready = 1'b0;
  logic                            o_busy, o_done;

  tile_buffer_reader dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_rows(i_num_rows), .i_wr_ptr(i_wr_ptr),
    .o_csb(o_csb), .o_we(o_we), .o_wmask(o_wmask), .o_addr(o_addr), .i_sram_dout(i_sram_dout),
    .o_pe_data(o_pe_data), .o_pe_valid(o_pe_valid), .i_pe_ready(i_pe_ready),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // SRAM: word appears on dout READ_LAT edges after the csb-low edge.
  logic [63:0] mem [SRAM_DEPTH];
  logic [63:0] sr_s1 = '0;
  always @(posedge clk) begin
    sr_s1       <= !o_csb ? mem[o_addr] : 64'hDEAD_BEEF_DEAD_BEEF;
    i_sram_dout <= sr_s1;
  end

  // Scoreboard: expected read order, row contents, hold stability.
  logic [ADDR_WIDTH-1:0] m_ptr = '0;
  int          rd_q[$];
  int          addr_log[$];
  int          n_reads = 0;
  int          n_acc = 0;
  bit          prev_hold = 0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      rd_q.delete();
      m_ptr = '0;
      prev_hold = 0;
    end else begin
      if (!o_csb) begin
        chk("rd_addr", o_addr, m_ptr);
        chk("rd_not_empty", (m_ptr != i_wr_ptr), 1);
        chk("rd_while_held", o_pe_valid, 0);
        rd_q.push_back(int'(o_addr));
        addr_log.push_back(int'(o_addr));
        m_ptr = m_ptr + 1'b1;
        n_reads++;
      end
      if (prev_hold) begin
        chk("hold_valid", o_pe_valid, 1);
        chk("hold_data", o_pe_data, prev_data);
      end
      if (o_pe_valid && i_pe_ready) begin
        if (rd_q.size() == 0) chk("spurious_row", 1, 0);
        else begin
          int a;
          a = rd_q.pop_front();
          chk("row_data", o_pe_data, mem[a] & 64'h0000_000F_FFFF_FFFF);
        end
        n_acc++;
        prev_hold = 0;
      end else begin
        prev_hold = o_pe_valid;
        prev_data = 64'(o_pe_data);
      end
    end
  end

  bit                    rnd_rdy = 0;
  bit                    trickle = 0;
  logic [ADDR_WIDTH-1:0] wr_tgt = '0;

  task automatic step();
    @(posedge clk); #1;
    if (rnd_rdy) i_pe_ready = 1'($urandom_range(0, 1));
    if (trickle && i_wr_ptr != wr_tgt && $urandom_range(0, 2) == 0) i_wr_ptr = i_wr_ptr + 1'b1;
  endtask

  task automatic pulse_start(input int n);
    i_num_rows = 16'(n);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int c = 0;
    while (!o_done && c < maxc) begin step(); c++; end
    if (!o_done) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_busy_at_done"}, o_busy, 0);
      step();
      chk({tag, "_done_one_cycle"}, o_done, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int c, base_r, base_a, n, p, sz;
    int exp_w[4];
    for (int i = 0; i < SRAM_DEPTH; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'h0000_0008_7654_3210;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_csb", o_csb, 1);
    chk("rst_we", o_we, 1);
    chk("rst_wmask", o_wmask, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_pe_data", o_pe_data, 0);
    chk("rst_pe_valid", o_pe_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    rst = 1'b0;
    step();

    // Single row, latency and pixel order.
    i_wr_ptr = 1; i_pe_ready = 1;
    pulse_start(1);
    c = 1;
    while (!o_pe_valid && c < 20) begin step(); c++; end
    chk("single_latency", c, READ_LAT + 2);
    chk("single_pe_data", o_pe_data, 36'h8_7654_3210);
    chk("single_addr", addr_log[0], 0);
    step();
    chk("single_done", o_done, 1);
    chk("single_busy", o_busy, 0);
    step();
    chk("single_done_clr", o_done, 0);

    // Backpressure with an ignored start in the middle.
    base_r = n_reads; base_a = n_acc;
    i_wr_ptr = 4; i_pe_ready = 0;
    pulse_start(3);
    c = 0;
    while (!o_pe_valid && c < 20) begin step(); c++; end
    chk("bp_valid", o_pe_valid, 1);
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin i_num_rows = 5; i_start = 1; end
      step();
      i_start = 0;
    end
    chk("bp_one_read", n_reads - base_r, 1);
    chk("bp_csb_idle", o_csb, 1);
    i_pe_ready = 1;
    wait_done("bp", 100);
    chk("bp_rows", n_acc - base_a, 3);
    repeat (6) step();
    chk("bp_start_not_queued", o_busy, 0);
    chk("bp_reads_total", n_reads - base_r, 3);

    // Zero-row job.
    base_r = n_reads;
    i_num_rows = 0; i_start = 1;
    step();
    i_start = 0;
    chk("zero_done", o_done, 1);
    chk("zero_busy", o_busy, 0);
    step();
    chk("zero_done_clr", o_done, 0);
    chk("zero_no_read", n_reads - base_r, 0);

    // Empty stall until the writer advances.
    base_r = n_reads; base_a = n_acc;
    pulse_start(2);
    repeat (8) step();
    chk("empty_busy", o_busy, 1);
    chk("empty_csb", o_csb, 1);
    chk("empty_no_read", n_reads - base_r, 0);
    i_wr_ptr = 6;
    wait_done("empty", 100);
    chk("empty_rows", n_acc - base_a, 2);

    // Random jobs: trickling writer, random ready.
    rnd_rdy = 1; trickle = 1;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 6);
      wr_tgt = m_ptr + ADDR_WIDTH'(n);
      base_a = n_acc;
      pulse_start(n);
      wait_done("rnd", 400);
      chk("rnd_rows", n_acc - base_a, n);
    end
    rnd_rdy = 0; trickle = 0; i_pe_ready = 1;

    // Walk rd_ptr up to 1022, then wrap.
    p = int'(m_ptr);
    i_wr_ptr = 1022;
    pulse_start(1022 - p);
    wait_done("fill", (1022 - p) * 6 + 50);
    chk("fill_ptr", o_addr, 1022);
    i_wr_ptr = 2;
    pulse_start(4);
    wait_done("wrap", 100);
    exp_w = '{1022, 1023, 0, 1};
    sz = addr_log.size();
    for (int k = 0; k < 4; k++) chk("wrap_addr", addr_log[sz - 4 + k], exp_w[k]);

    // Reset while a read is in flight.
    i_wr_ptr = 3;
    pulse_start(1);
    step();
    #1 rst = 1'b1;
    #1;
    chk("midrst_csb", o_csb, 1);
    chk("midrst_we", o_we, 1);
    chk("midrst_valid", o_pe_valid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_ptr", o_addr, 0);
    i_wr_ptr = 1;
    step(); step();
    rst = 1'b0;
    repeat (4) step();
    chk("postrst_valid", o_pe_valid, 0);
    base_a = n_acc;
    pulse_start(1);
    wait_done("postrst", 50);
    chk("postrst_rows", n_acc - base_a, 1);
    chk("postrst_addr", addr_log[addr_log.size() - 1], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
